philox_stream_ctrl: RTL and testbench

- Sequences one philox4x32_10 core to produce a requested number of 128-bit blocks.
- Holds key and counter stable for the core. Issues one block at a time, waits the core latency, then captures the result.
- Serialises each block into four 32-bit words on a valid/ready stream.
- Sits between the config/CSR side (start, seed, count) and any random-number consumer.

---
 rtl/philox_stream_ctrl_if.sv | 26 ++
 rtl/philox_stream_ctrl.sv | 141 ++++++++++++++
 tb/tb_philox_stream_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/philox_stream_ctrl_if.sv
// Random-word stream between philox_stream_ctrl and a consumer.
//   rnd_data  : 32-bit output word
//   rnd_valid : rnd_data is valid
//   rnd_ready : consumer accepts the word
//   rnd_last  : final word of the run
// The master modport is the producer (controller); the slave modport is the consumer.
interface philox_stream_ctrl_if;
    logic [31:0] rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        rnd_last;

    modport master (
        output rnd_data,
        output rnd_valid,
        output rnd_last,
        input  rnd_ready
    );

    modport slave (
        input  rnd_data,
        input  rnd_valid,
        input  rnd_last,
        output rnd_ready
    );
endinterface

// File: rtl/philox_stream_ctrl.sv
// Sequences an external philox4x32_10 core to produce cfg_nblocks 128-bit blocks. Each block is
// then emitted as four 32-bit words (bits 31:0 first) on a valid/ready stream.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, abort   : launch a run (sampled only when idle) / cancel the current run
//   cfg_key/counter/nblocks : run configuration, latched on an accepted start
//   busy, done     : busy outside IDLE; done pulses for one cycle on normal completion
//   ctr_next       : counter value the next block will use (continues the stream afterwards)
//   core_en/counter/key, core_out : core request (one-cycle enable) and result
//   rnd            : output word stream (master side)
module philox_stream_ctrl #(
    parameter int unsigned CORE_LAT = 1,
    parameter int unsigned NB_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [63:0]         cfg_key,
    input  logic [127:0]        cfg_counter,
    input  logic [NB_W-1:0]     cfg_nblocks,
    output logic                busy,
    output logic                done,
    output logic [127:0]        ctr_next,
    output logic                core_en,
    output logic [127:0]        core_counter,
    output logic [63:0]         core_key,
    input  logic [127:0]        core_out,
    philox_stream_ctrl_if.master rnd
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StDone} state_e;

    localparam logic [7:0] WaitInit = 8'(CORE_LAT - 1);

    state_e          state_q;
    logic [95:0]     buf_q;     // words 1..3 still to be sent; word 0 goes straight to rnd_data
    logic [1:0]      idx_q;
    logic [NB_W-1:0] remain_q;
    logic [7:0]      wait_q;

    logic [127:0]    ctr_inc;
    logic [NB_W-1:0] remain_dec;

    assign ctr_inc    = ctr_next + 128'd1;
    assign remain_dec = remain_q - NB_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            busy          <= 1'b0;
            done          <= 1'b0;
            ctr_next      <= '0;
            core_en       <= 1'b0;
            core_counter  <= '0;
            core_key      <= '0;
            rnd.rnd_data  <= '0;
            rnd.rnd_valid <= 1'b0;
            rnd.rnd_last  <= 1'b0;
            buf_q         <= '0;
            idx_q         <= '0;
            remain_q      <= '0;
            wait_q        <= '0;
        end else if (abort && (state_q != StIdle)) begin
            // Abort wins over any handshake in the same cycle; ctr_next is left untouched.
            state_q       <= StIdle;
            busy          <= 1'b0;
            done          <= 1'b0;
            core_en       <= 1'b0;
            rnd.rnd_valid <= 1'b0;
            rnd.rnd_last  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        core_key     <= cfg_key;
                        ctr_next     <= cfg_counter;
                        core_counter <= cfg_counter;
                        remain_q     <= cfg_nblocks;
                        busy         <= 1'b1;
                        if (cfg_nblocks == '0) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            core_en <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    core_en <= 1'b0;
                    wait_q  <= WaitInit;
                    state_q <= StWait;
                end
                StWait: begin
                    if (wait_q == 8'd0) begin
                        buf_q         <= core_out[127:32];
                        rnd.rnd_data  <= core_out[31:0];
                        rnd.rnd_valid <= 1'b1;
                        rnd.rnd_last  <= 1'b0;
                        idx_q         <= 2'd0;
                        state_q       <= StDrain;
                    end else begin
                        wait_q <= wait_q - 8'd1;
                    end
                end
                StDrain: begin
                    // rnd_valid is always high here, so ready alone completes a handshake.
                    if (rnd.rnd_ready) begin
                        idx_q        <= idx_q + 2'd1;
                        rnd.rnd_data <= buf_q[31:0];
                        buf_q        <= {32'h0, buf_q[95:32]};
                        if (idx_q == 2'd2) begin
                            rnd.rnd_last <= (remain_q == NB_W'(1));
                        end
                        if (idx_q == 2'd3) begin
                            ctr_next      <= ctr_inc;
                            remain_q      <= remain_dec;
                            rnd.rnd_valid <= 1'b0;
                            rnd.rnd_last  <= 1'b0;
                            if (remain_dec != '0) begin
                                core_counter <= ctr_inc;
                                core_en      <= 1'b1;
                                state_q      <= StIssue;
                            end else begin
                                done    <= 1'b1;
                                state_q <= StDone;
                            end
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_philox_stream_ctrl.sv
// Bench for philox_stream_ctrl: two instances (core latency 1 and 3) share config, start, abort
// and rnd_ready; each has its own core model (stub XOR or a behavioural philox4x32_10).
module tb_philox_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, rnd_ready;
    logic [63:0]  cfg_key;
    logic [127:0] cfg_counter;
    logic [15:0]  cfg_nblocks;
    bit           use_real = 1'b0;

    logic         busy1, done1, core_en1, busy3, done3, core_en3;
    logic [127:0] ctr_next1, core_counter1, core_out1, ctr_next3, core_counter3, core_out3;
    logic [63:0]  core_key1, core_key3;
    logic [127:0] c3_p0, c3_p1;

    philox_stream_ctrl_if if1();
    philox_stream_ctrl_if if3();
    assign if1.rnd_ready = rnd_ready;
    assign if3.rnd_ready = rnd_ready;

    always #5 clk = ~clk;

    philox_stream_ctrl #(.CORE_LAT(1), .NB_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_key(cfg_key),
        .cfg_counter(cfg_counter), .cfg_nblocks(cfg_nblocks), .busy(busy1), .done(done1),
        .ctr_next(ctr_next1), .core_en(core_en1), .core_counter(core_counter1),
        .core_key(core_key1), .core_out(core_out1), .rnd(if1)
    );

    philox_stream_ctrl #(.CORE_LAT(3), .NB_W(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_key(cfg_key),
        .cfg_counter(cfg_counter), .cfg_nblocks(cfg_nblocks), .busy(busy3), .done(done3),
        .ctr_next(ctr_next3), .core_en(core_en3), .core_counter(core_counter3),
        .core_key(core_key3), .core_out(core_out3), .rnd(if3)
    );

    function automatic logic [127:0] philox(input logic [127:0] c, input logic [63:0] k);
        logic [31:0] x0, x1, x2, x3, k0, k1;
        logic [63:0] p0, p1;
        {x3, x2, x1, x0} = c;
        {k1, k0} = k;
        for (int r = 0; r < 10; r++) begin
            p0 = {32'h0, 32'hD2511F53} * {32'h0, x0};
            p1 = {32'h0, 32'hCD9E8D57} * {32'h0, x2};
            {x0, x1, x2, x3} = {p1[63:32] ^ x1 ^ k0, p1[31:0], p0[63:32] ^ x3 ^ k1, p0[31:0]};
            k0 = k0 + 32'h9E3779B9;
            k1 = k1 + 32'hBB67AE85;
        end
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [127:0] core_fn(input logic [127:0] c, input logic [63:0] k);
        return use_real ? philox(c, k) : (c ^ {k, k});
    endfunction

    // Core models: the result is only present on the edge CORE_LAT after core_en is sampled;
    // otherwise a junk pattern shows up, so a mistimed capture is visible.
    localparam logic [127:0] Junk = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    always @(posedge clk) begin
        core_out1 <= core_en1 ? core_fn(core_counter1, core_key1) : Junk;
        c3_p0     <= core_en3 ? core_fn(core_counter3, core_key3) : Junk;
        c3_p1     <= c3_p0;
        core_out3 <= c3_p1;
    end

    // Stream and core-request monitors.
    logic [31:0]  w1[$], w3[$];
    bit           l1[$], l3[$];
    logic [127:0] cc3[$];
    int           en1 = 0, en3 = 0, dn1 = 0, dn3 = 0;

    always @(posedge clk) begin
        if (if1.rnd_valid && rnd_ready) begin w1.push_back(if1.rnd_data); l1.push_back(if1.rnd_last); end
        if (if3.rnd_valid && rnd_ready) begin w3.push_back(if3.rnd_data); l3.push_back(if3.rnd_last); end
        if (core_en1) en1 <= en1 + 1;
        if (core_en3) begin en3 <= en3 + 1; cc3.push_back(core_counter3); end
        if (done1) dn1 <= dn1 + 1;
        if (done3) dn3 <= dn3 + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input bit sel3, input string tag);
        chk({tag, " busy"},   sel3 ? busy3 : busy1, 0);
        chk({tag, " done"},   sel3 ? done3 : done1, 0);
        chk({tag, " core_en"}, sel3 ? core_en3 : core_en1, 0);
        chk({tag, " valid"},  sel3 ? if3.rnd_valid : if1.rnd_valid, 0);
        chk({tag, " last"},   sel3 ? if3.rnd_last : if1.rnd_last, 0);
        chk({tag, " data"},   sel3 ? if3.rnd_data : if1.rnd_data, 0);
        chk({tag, " core_counter"}, sel3 ? core_counter3 : core_counter1, 0);
        chk({tag, " ctr_next"}, sel3 ? ctr_next3 : ctr_next1, 0);
        chk({tag, " core_key"}, sel3 ? core_key3 : core_key1, 0);
    endtask

    // Pulses start, then watches the selected instance at negedges. k counts edges after the
    // one that sampled start: a value first seen at negedge k is sampled by that edge + k.
    task automatic run(input string tag, input bit sel3, input bit toggle, input int restart_k,
                       output int vlat, output int dlat, output int lastk, output int stab_err);
        logic v, l, dn, pv, pr, pl;
        logic [31:0] d, pd;
        vlat = -1; dlat = -1; lastk = -1; stab_err = 0;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = (k == restart_k);
            v  = sel3 ? if3.rnd_valid : if1.rnd_valid;
            l  = sel3 ? if3.rnd_last  : if1.rnd_last;
            d  = sel3 ? if3.rnd_data  : if1.rnd_data;
            dn = sel3 ? done3 : done1;
            if (v && vlat < 0) vlat = k;
            if (pv && !pr && (!v || d !== pd || l !== pl)) stab_err++;
            if (v && l && rnd_ready) lastk = k;
            if (dn && dlat < 0) dlat = k;
            if (toggle) rnd_ready = ~rnd_ready;
            pv = v; pd = d; pl = l; pr = rnd_ready;
            if (dlat >= 0 && !busy1 && !busy3) break;
        end
        start = 1'b0;
        chk({tag, " done seen"}, (dlat >= 0), 1);
        chk({tag, " idle after run"}, busy1 | busy3, 0);
    endtask

    typedef struct packed {
        bit           real_core;
        logic [63:0]  key;
        logic [127:0] ctr;
        logic [15:0]  nb;
        logic [127:0] exp_first;   // word 0 in bits 31:0
        logic [127:0] exp_last;
        logic [127:0] exp_ctr;
    } vec_t;

    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int vl, dl, lk, se, nw, bw, be, bd, bd3, bc, nl;
        logic [127:0] blk;

        vt[0] = '{1'b0, 64'h0, 128'h1, 16'd1,
                  128'h00000000_00000000_00000000_00000001,
                  128'h00000000_00000000_00000000_00000001, 128'h2};
        vt[1] = '{1'b1, 64'h0, 128'h0, 16'd1,
                  128'h9b00dbd8_bc57ac4c_e169c58d_6627e8d5,
                  128'h9b00dbd8_bc57ac4c_e169c58d_6627e8d5, 128'h1};
        vt[2] = '{1'b0, 64'h01234567_89abcdef, 128'h00000004_00000003_00000002_00000001, 16'd2,
                  128'h01234563_89abcdec_01234565_89abcdee,
                  128'h01234563_89abcdec_01234565_89abcded,
                  128'h00000004_00000003_00000002_00000003};
        vt[3] = '{1'b0, 64'h0, {128{1'b1}}, 16'd2, {128{1'b1}}, 128'h0, 128'h1};
        vt[4] = '{1'b0, 64'h0, 128'h55, 16'd0, 128'h0, 128'h0, 128'h55};

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; rnd_ready = 1'b1;
        cfg_key = '0; cfg_counter = '0; cfg_nblocks = '0;
        #1 rst_n = 1'b0;
        #2;
        chk_rst(1'b0, "reset1");
        chk_rst(1'b1, "reset3");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Table: latency-1 instance, consumer always ready.
        for (int i = 0; i < 5; i++) begin
            use_real = vt[i].real_core;
            cfg_key = vt[i].key; cfg_counter = vt[i].ctr; cfg_nblocks = vt[i].nb;
            bw = w1.size(); be = en1; bd = dn1;
            run($sformatf("v%0d", i), 1'b0, 1'b0, 0, vl, dl, lk, se);
            nw = w1.size() - bw;
            chk($sformatf("v%0d word count", i), nw, 4 * int'(vt[i].nb));
            chk($sformatf("v%0d core_en count", i), en1 - be, vt[i].nb);
            chk($sformatf("v%0d done count", i), dn1 - bd, 1);
            chk($sformatf("v%0d ctr_next", i), ctr_next1, vt[i].exp_ctr);
            if (vt[i].nb != 0 && nw == 4 * int'(vt[i].nb)) begin
                blk = {w1[bw+3], w1[bw+2], w1[bw+1], w1[bw]};
                chk($sformatf("v%0d first block", i), blk, vt[i].exp_first);
                blk = {w1[bw+nw-1], w1[bw+nw-2], w1[bw+nw-3], w1[bw+nw-4]};
                chk($sformatf("v%0d last block", i), blk, vt[i].exp_last);
                nl = 0;
                for (int j = bw; j < bw + nw; j++) nl += int'(l1[j]);
                chk($sformatf("v%0d rnd_last count", i), nl, 1);
                chk($sformatf("v%0d rnd_last on final word", i), l1[bw+nw-1], 1);
                chk($sformatf("v%0d first valid latency", i), vl, 3);
                chk($sformatf("v%0d done after last word", i), dl, lk + 1);
            end else if (vt[i].nb == 0) begin
                chk($sformatf("v%0d valid seen", i), (vl >= 0), 0);
                // DONE is entered on the edge that samples start (second edge after start rises).
                chk($sformatf("v%0d done latency", i), dl, 1);
            end
        end

        // Latency-3 instance, ready toggling; counter carries across a word boundary.
        use_real = 1'b0;
        cfg_key = 64'hA5A5A5A5_5A5A5A5A; cfg_counter = 128'hFFFFFFFE; cfg_nblocks = 16'd3;
        bw = w3.size(); bc = cc3.size(); be = en3;
        run("toggle", 1'b1, 1'b1, 0, vl, dl, lk, se);
        rnd_ready = 1'b1;
        nw = w3.size() - bw;
        chk("toggle word count", nw, 12);
        chk("toggle stability errors", se, 0);
        chk("toggle core_en count", en3 - be, 3);
        chk("toggle first valid latency", vl, 5);
        chk("toggle ctr_next", ctr_next3, 128'h1_00000001);
        if (cc3.size() - bc == 3) begin
            chk("toggle core_counter 0", cc3[bc],   128'hFFFFFFFE);
            chk("toggle core_counter 1", cc3[bc+1], 128'hFFFFFFFF);
            chk("toggle core_counter 2", cc3[bc+2], 128'h1_00000000);
        end
        if (nw == 12) begin
            chk("toggle block 0", {w3[bw+3], w3[bw+2], w3[bw+1], w3[bw]},
                128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_A5A5A5A4);
            chk("toggle block 2", {w3[bw+11], w3[bw+10], w3[bw+9], w3[bw+8]},
                128'hA5A5A5A5_5A5A5A5A_A5A5A5A4_5A5A5A5A);
        end

        // A second start while busy is ignored.
        cfg_key = '0; cfg_counter = 128'h10; cfg_nblocks = 16'd2;
        bw = w1.size(); bd = dn1; bd3 = dn3;
        run("restart", 1'b0, 1'b0, 5, vl, dl, lk, se);
        chk("restart word count", w1.size() - bw, 8);
        chk("restart done count", dn1 - bd, 1);
        chk("restart done count L3", dn3 - bd3, 1);
        chk("restart ctr_next", ctr_next1, 128'h12);

        // Abort on the edge ending the first WAIT cycle of block 2 on the latency-3 instance.
        cfg_key = 64'h1; cfg_counter = 128'h40; cfg_nblocks = 16'd3;
        bd = dn1; bd3 = dn3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort pre busy", busy3, 1);
        chk("abort pre core_en", core_en3, 0);
        chk("abort pre valid", if3.rnd_valid, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", busy3, 0);
        chk("abort valid", if3.rnd_valid, 0);
        chk("abort ctr_next", ctr_next3, 128'h41);
        chk("abort busy L1", busy1, 0);
        chk("abort ctr_next L1", ctr_next1, 128'h41);
        repeat (10) @(negedge clk);
        chk("abort no done", (dn3 - bd3) + (dn1 - bd), 0);
        chk("abort stays idle", busy3 | core_en3 | if3.rnd_valid, 0);

        // Reset while the latency-3 instance holds its first word.
        rnd_ready = 1'b0;
        cfg_key = 64'hFEDCBA98_76543210; cfg_counter = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
        cfg_nblocks = 16'd1;
        bd = dn1; bd3 = dn3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre-reset valid", if3.rnd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk_rst(1'b1, "midrun3");
        chk_rst(1'b0, "midrun1");
        @(negedge clk);
        rst_n = 1'b1;
        rnd_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset no done", (dn3 - bd3) + (dn1 - bd), 0);
        chk("reset stays idle", busy3 | busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
